// File: rtl/ft_adder_pipe.sv
// Fault-tolerant two-stage adder: TMR ripple-carry replicas with majority vote,
// an independent checker adder, a two-rail error tree and a one-shot retry FSM.

module ft_rca #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             inj,
  input  logic [WIDTH:0]   mask,
  output logic [WIDTH:0]   res
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign res = {c[WIDTH], s} ^ (inj ? mask : '0);
endmodule

module ft_adder_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             par,
  input  logic [2:0]       ctrl,
  input  logic [3:0]       inj_sel,
  input  logic [WIDTH:0]   inj_mask,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] corr_cnt,
  output logic             fatal
);
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] RETRY = 1'b1;
  localparam int NP = WIDTH + 3;  // sum/cout pairs + parity pair + ctrl pair

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             par;
    logic [2:0]       ctrl;
  } word_t;

  logic [0:0]           state;
  logic [1:0]           vld_pipe;  // [0] = S1 holds a word, [1] = output valid
  word_t                s1, skid, in_w;
  logic                 skid_vld, accept;
  logic [WIDTH-1:0]     op_x, op_y;
  logic                 op_cin, onehot, par_ok, code_err;
  logic [2:0][WIDTH:0]  rep;
  logic [WIDTH:0]       chk, vote;
  logic [2:0]           rep_bad;
  logic                 one_bad, mis, emit;
  logic [NP-1:0]        rx, ry;
  logic [1:0]           tr;

  assign in_ready = (state == RUN) & ~rst;
  assign accept   = in_valid & in_ready;
  assign in_w     = '{a: a, b: b, par: par, ctrl: ctrl};

  assign onehot   = (s1.ctrl == 3'b001) | (s1.ctrl == 3'b010) | (s1.ctrl == 3'b100);
  assign par_ok   = (s1.par == ^{s1.a, s1.b});
  assign code_err = ~par_ok | ~onehot;

  // Non-one-hot codes fall through to a+b.
  always_comb begin
    op_x   = s1.a;
    op_y   = s1.b;
    op_cin = 1'b0;
    if (s1.ctrl == 3'b010) begin
      op_y   = ~s1.b;
      op_cin = 1'b1;
    end else if (s1.ctrl == 3'b100) begin
      op_x   = ~s1.a;
      op_cin = 1'b1;
    end
  end

  ft_rca #(.WIDTH(WIDTH)) u_rep [2:0] (
    .x(op_x), .y(op_y), .cin(op_cin), .inj(inj_sel[2:0]), .mask(inj_mask), .res(rep)
  );

  ft_rca #(.WIDTH(WIDTH)) u_chk (
    .x(op_x), .y(op_y), .cin(op_cin), .inj(inj_sel[3]), .mask(inj_mask), .res(chk)
  );

  assign vote    = (rep[0] & rep[1]) | (rep[0] & rep[2]) | (rep[1] & rep[2]);
  assign rep_bad = {rep[2] != vote, rep[1] != vote, rep[0] != vote};
  assign one_bad = (rep_bad == 3'b001) | (rep_bad == 3'b010) | (rep_bad == 3'b100);
  assign mis     = vld_pipe[0] & (chk != vote);
  assign emit    = vld_pipe[0] & (~mis | (state == RETRY));

  // Every pair is complementary when clean; ctrl rail (onehot,0) collapses to 00 on a bad code.
  assign rx = {vote, s1.par, onehot};
  assign ry = {~chk, ~^{s1.a, s1.b}, 1'b0};

  always_comb begin
    tr = {rx[0], ry[0]};
    for (int i = 1; i < NP; i++)
      tr = {(tr[1] & rx[i]) | (tr[0] & ry[i]), (tr[1] & ry[i]) | (tr[0] & rx[i])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      vld_pipe <= '0;
      skid_vld <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_err  <= 2'b01;
      corr_cnt <= '0;
      fatal    <= 1'b0;
    end else begin
      vld_pipe[1] <= emit;
      if (emit) begin
        {out_cout, out_sum} <= vote;
        out_err             <= tr;
      end else begin
        out_err <= 2'b01;
      end
      if (emit & ~mis & one_bad & ~code_err & ~&corr_cnt)
        corr_cnt <= corr_cnt + 1'b1;
      if ((state == RETRY) & mis)
        fatal <= 1'b1;

      // A word accepted on the edge that enters RETRY parks in skid until S1 frees up.
      if (state == RUN) begin
        if (mis) begin
          state <= RETRY;
          if (accept) begin
            skid     <= in_w;
            skid_vld <= 1'b1;
          end
        end else begin
          vld_pipe[0] <= accept;
          if (accept) s1 <= in_w;
        end
      end else begin
        state       <= RUN;
        vld_pipe[0] <= skid_vld;
        skid_vld    <= 1'b0;
        if (skid_vld) s1 <= skid;
      end
    end
  end

  assign out_valid = vld_pipe[1];
endmodule

// File: tb/tb_ft_adder_pipe.sv
// Scoreboard bench for ft_adder_pipe: driver pushes model results, monitor pops on out_valid.

module tb_ft_adder_pipe;
  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0, b = '0;
  logic          par = 1'b0;
  logic [2:0]    ctrl = 3'b001;
  logic [3:0]    inj_sel = '0;
  logic [W:0]    inj_mask = '0;
  logic          out_valid;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic [1:0]    out_err;
  logic [CW-1:0] corr_cnt;
  logic          fatal;

  ft_adder_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .par(par), .ctrl(ctrl), .inj_sel(inj_sel), .inj_mask(inj_mask),
    .out_valid(out_valid), .out_sum(out_sum), .out_cout(out_cout),
    .out_err(out_err), .corr_cnt(corr_cnt), .fatal(fatal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int cout;
    bit clean;
    bit corr;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   mon_cnt = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(int av, int bv, logic [2:0] c, logic p);
    exp_t e;
    int   r;
    bit   oh;
    int   pty;
    oh  = (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
    pty = ($countones(av) + $countones(bv)) % 2;
    if (c == 3'b010)      r = av - bv + (1 << W);
    else if (c == 3'b100) r = bv - av + (1 << W);
    else                  r = av + bv;
    e.sum   = r % (1 << W);
    e.cout  = (r >> W) & 1;
    e.clean = oh && (int'(p) == pty);
    e.corr  = 1'b0;
    return e;
  endfunction

  // Called on a negedge; returns on the negedge right after the accepting edge.
  task automatic send(int av, int bv, logic [2:0] c, logic p, bit corr, bit force_err);
    exp_t e;
    int   guard;
    guard    = 0;
    a        = W'(av);
    b        = W'(bv);
    ctrl     = c;
    par      = p;
    in_valid = 1'b1;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready stuck low, expected high within 20 cycles");
    end else begin
      e = model(av, bv, c, p);
      if (force_err) e.clean = 1'b0;
      e.corr = corr && e.clean;
      sbq.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out sum=%0d with empty scoreboard, expected no output", out_sum);
        end else begin
          mon_e = sbq.pop_front();
          chk("out_sum", int'(out_sum), mon_e.sum);
          chk("out_cout", int'(out_cout), mon_e.cout);
          chk("out_err_clean", int'(out_err[0] ^ out_err[1]), int'(mon_e.clean));
          if (mon_e.corr && mon_cnt < (1 << CW) - 1) mon_cnt++;
          chk("corr_cnt", int'(corr_cnt), mon_cnt);
        end
      end else begin
        chk("out_err_idle", int'(out_err), 1);
      end
    end
  end

  initial begin
    int r;
    logic [2:0] c;
    logic p;
    int av, bv, guard;

    idle(3);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_cout", int'(out_cout), 0);
    chk("rst_out_err", int'(out_err), 1);
    chk("rst_corr_cnt", int'(corr_cnt), 0);
    chk("rst_fatal", int'(fatal), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", int'(in_ready), 1);
    @(negedge clk);

    // Latency: nothing on the negedge after acceptance, pulse one cycle later.
    send(5, 3, 3'b001, 1'b0, 1'b0, 1'b0);
    chk("lat_early", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_two_edges", int'(out_valid), 1);
    send(5, 3, 3'b010, 1'b0, 1'b0, 1'b0);
    send(5, 3, 3'b100, 1'b0, 1'b0, 1'b0);
    send(5, 3, 3'b001, 1'b1, 1'b0, 1'b0);
    send(5, 3, 3'b011, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Random single-replica faults: masked by the vote and counted.
    inj_sel  = 4'b0001 << $urandom_range(0, 2);
    inj_mask = 5'($urandom_range(1, 31));
    for (int i = 0; i < 12; i++) begin
      av = $urandom_range(0, 15);
      bv = $urandom_range(0, 15);
      send(av, bv, 3'b001 << $urandom_range(0, 2), 1'($countones(av) + $countones(bv)),
           1'b1, 1'b0);
    end
    idle(1);
    inj_sel = '0;
    idle(3);

    // Back-to-back clean stream: 8 words on consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      av = $urandom_range(0, 15);
      bv = $urandom_range(0, 15);
      send(av, bv, 3'b001 << (i % 3), 1'($countones(av) + $countones(bv)), 1'b0, 1'b0);
    end
    idle(3);

    // Random mix of ops, bad codes, bad parity and input gaps.
    for (int i = 0; i < 100; i++) begin
      r  = $urandom_range(0, 9);
      c  = (r < 9) ? (3'b001 << (r % 3)) : 3'($urandom_range(0, 7));
      av = $urandom_range(0, 15);
      bv = $urandom_range(0, 15);
      p  = 1'($countones(av) + $countones(bv));
      if ($urandom_range(0, 9) == 0) p = ~p;
      send(av, bv, c, p, 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(3);

    // Replica 1 bit-0 fault on 20 words: counter saturates.
    inj_sel  = 4'b0010;
    inj_mask = 5'b00001;
    for (int i = 0; i < 20; i++) send(5, 3, 3'b001, 1'b0, 1'b1, 1'b0);
    idle(1);
    inj_sel = '0;
    idle(3);
    chk("corr_sat", int'(corr_cnt), 15);

    // Checker fault on the first attempt only: one retry, correct result.
    inj_mask = 5'b00001;
    send(7, 6, 3'b001, 1'b1, 1'b0, 1'b0);
    inj_sel = 4'b1000;
    @(negedge clk);
    chk("retry_in_ready", int'(in_ready), 0);
    chk("retry_no_valid", int'(out_valid), 0);
    inj_sel = '0;
    @(negedge clk);
    chk("retry_valid_lat3", int'(out_valid), 1);
    chk("retry_fatal", int'(fatal), 0);
    idle(2);

    // Word accepted on the edge that enters retry must still come out, in order.
    send(2, 9, 3'b001, 1'b1, 1'b0, 1'b0);
    inj_sel = 4'b1000;
    send(9, 9, 3'b010, 1'b0, 1'b0, 1'b0);
    inj_sel = '0;
    idle(5);

    // Reset during retry drops the held word.
    send(1, 1, 3'b001, 1'b0, 1'b0, 1'b0);
    inj_sel = 4'b1000;
    @(negedge clk);
    chk("rst_retry_in_ready", int'(in_ready), 0);
    rst     = 1'b1;
    inj_sel = '0;
    @(negedge clk);
    chk("rst_retry_pending", sbq.size(), 1);
    sbq.delete();
    mon_cnt = 0;
    rst = 1'b0;
    idle(4);
    chk("rst_retry_corr", int'(corr_cnt), 0);

    // Persistent checker fault: flagged result, sticky fatal.
    inj_sel = 4'b1000;
    send(4, 4, 3'b001, 1'b0, 1'b0, 1'b1);
    idle(4);
    chk("fatal_set", int'(fatal), 1);
    inj_sel = '0;
    send(3, 2, 3'b001, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("fatal_sticky", int'(fatal), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("fatal_cleared", int'(fatal), 0);
    mon_cnt = 0;

    guard = 0;
    while (sbq.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard_drained", sbq.size(), 0);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ft_adder_pipe.md
FT_ADDER_PIPE -- requirements
Module: ft_adder_pipe

Interface
REQ-001 Parameter WIDTH, 4, operand width in bits; legal range 2..16.
REQ-002 Parameter CNT_W, 4, width of the corrected-error counter.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand word present.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 par  input  1  parity bit; equals XOR of all a and b bits.
REQ-010 ctrl  input  3  one-hot op: 001 = a+b, 010 = a-b, 100 = b-a.
REQ-011 inj_sel  input  4  fault injection enable: bits 0..2 = replica 0..2, bit 3 = checker adder.
REQ-012 inj_mask  input  WIDTH+1  XOR mask applied to the {cout,sum} of each selected adder while asserted.
REQ-013 out_valid  output  1  result valid, one-cycle pulse per accepted word.
REQ-014 out_sum, out_cout  output  WIDTH, 1  voted result.
REQ-015 out_err  output  2  two-rail error pair: 01/10 = clean, 00/11 = error.
REQ-016 corr_cnt  output  CNT_W  saturating count of masked replica faults.
REQ-017 fatal  output  1  sticky unrecoverable-error flag.

Function
REQ-018 Op mapping: 001 -> a + b + 0; 010 -> a + ~b + 1; 100 -> ~a + b + 1; non-one-hot ctrl executes as 001.
REQ-019 Stage S1: {a,b,par,ctrl} registered on an edge where in_valid & in_ready.
REQ-020 Stage S2: three replica ripple-carry adders plus one independent checker adder operate on S1 contents; the bitwise majority of the replicas is registered to out_sum/out_cout.
REQ-021 Checker outputs enter the two-rail tree inverted against the voted result; parity (par vs. XOR of operands) and ctrl (one-hot check) also enter the tree as complementary pairs.
REQ-022 Latency: out_valid rises 2 edges after the accepting edge with no retry, 3 edges with retry; throughput 1 word/cycle in RUN.
REQ-023 FSM states RUN, RETRY; in_ready = (state == RUN) & ~rst.
REQ-024 RUN -> RETRY when the checker disagrees with the voted result; S1 is held and recomputed for exactly one cycle; no out_valid for the first attempt.
REQ-025 RETRY -> RUN always after one cycle; if the checker disagrees again, emit the voted result with out_err non-complementary and set fatal.
REQ-026 If exactly one replica differs from the vote and the checker agrees, emit the result with clean out_err and increment corr_cnt (saturate at all-ones).
REQ-027 Parity or ctrl code error: no retry; result emitted on normal latency with out_err non-complementary; corr_cnt unchanged.
REQ-028 When multiple events coincide in one cycle, checker mismatch takes precedence over replica-correction counting; corr_cnt counts once per emitted word.
REQ-029 out_sum/out_cout hold their last value when out_valid = 0; out_err returns to 01 when out_valid = 0.

Reset
REQ-030 rst clears S1 valid, out_valid = 0, out_sum = 0, out_cout = 0, out_err = 01, corr_cnt = 0, fatal = 0, state = RUN.
REQ-031 rst asserted in RETRY discards the held word; no out_valid is produced for it.
REQ-032 fatal clears only on rst.

Verification
REQ-033 WIDTH=4, a=5, b=3, ctrl=001, par=0 -> two edges later: out_sum=8, out_cout=0, out_err clean.
REQ-034 a=5, b=3, ctrl=010, par=0 -> out_sum=2, out_cout=1, clean; b-a (ctrl=100) -> out_sum=14, out_cout=0.
REQ-035 inj_sel=0010, inj_mask=00001 on a+b -> correct sum, clean out_err, corr_cnt increments by 1; 20 such words -> corr_cnt saturates at 15.
REQ-036 inj_sel=1000 for the first attempt only -> in_ready low 1 cycle, correct result at latency 3, fatal=0; inj_sel=1000 held -> out_err non-complementary, fatal=1 until rst.
REQ-037 par=1 with a=5, b=3 or ctrl=011 -> result on normal latency, out_err non-complementary, no retry.
REQ-038 Back-to-back stream of 8 words with no faults -> 8 out_valid pulses on consecutive cycles, in order.
